// File: rtl/wb_queue.sv
// Write-back queue feeding the register file write port (regW/wrA/wrD).
// Buffers results, drains one per clock, and exposes a pending scoreboard plus read-port bypass.

module wb_byp #(
  parameter int DEPTH = 4
) (
  input  logic                   [4:0] ra,
  input  logic       [DEPTH-1:0]       age_vld,
  input  logic       [DEPTH-1:0][4:0]  age_addr,
  input  logic       [DEPTH-1:0][31:0] age_data,
  input  logic                         regW,
  input  logic                   [4:0] wrA,
  input  logic                  [31:0] wrD,
  output logic                         hit,
  output logic                  [31:0] data
);
  // Entries are age-ordered oldest first, so a later match overrides; the output stage is oldest of all.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (ra != 5'd0) begin
      if (regW && (wrA == ra)) begin
        hit  = 1'b1;
        data = wrD;
      end
      for (int j = 0; j < DEPTH; j++) begin
        if (age_vld[j] && (age_addr[j] == ra)) begin
          hit  = 1'b1;
          data = age_data[j];
        end
      end
    end
  end
endmodule

module wb_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_addr,
  input  logic [31:0]   in_data,
  input  logic          wb_hold,
  output logic          regW,
  output logic [4:0]    wrA,
  output logic [31:0]   wrD,
  input  logic [4:0]    r1A,
  input  logic [4:0]    r2A,
  output logic          byp1_hit,
  output logic [31:0]   byp1_data,
  output logic          byp2_hit,
  output logic [31:0]   byp2_data,
  output logic [31:0]   pending,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t       q [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop;

  assign in_ready = ~rst & (count < CW'(DEPTH));
  // Writes to r0 are accepted but dropped so they never occupy a slot.
  assign push     = in_valid & in_ready & (in_addr != 5'd0);
  assign pop      = ~wb_hold & (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      regW  <= 1'b0;
      wrA   <= '0;
      wrD   <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        regW <= 1'b1;
        wrA  <= q[rptr].addr;
        wrD  <= q[rptr].data;
      end else begin
        regW <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[wptr] <= '{addr: in_addr, data: in_data};
  end

  logic [DEPTH-1:0]       age_vld;
  logic [DEPTH-1:0][4:0]  age_addr;
  logic [DEPTH-1:0][31:0] age_data;

  // Slot j in age order lives at rptr+j; valid while j is below the occupancy.
  for (genvar j = 0; j < DEPTH; j++) begin : g_age
    assign age_vld[j]  = CW'(j) < count;
    assign age_addr[j] = q[rptr + AW'(j)].addr;
    assign age_data[j] = q[rptr + AW'(j)].data;
  end

  always_comb begin
    pending = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (age_vld[j]) pending[age_addr[j]] = 1'b1;
    end
    if (regW) pending[wrA] = 1'b1;
    pending[0] = 1'b0;
  end

  logic [1:0][4:0]  byp_ra;
  logic [1:0]       byp_hit;
  logic [1:0][31:0] byp_data;

  assign byp_ra = {r2A, r1A};

  for (genvar p = 0; p < 2; p++) begin : g_byp
    wb_byp #(.DEPTH(DEPTH)) u_byp (
      .ra       (byp_ra[p]),
      .age_vld  (age_vld),
      .age_addr (age_addr),
      .age_data (age_data),
      .regW     (regW),
      .wrA      (wrA),
      .wrD      (wrD),
      .hit      (byp_hit[p]),
      .data     (byp_data[p])
    );
  end

  assign byp1_hit  = byp_hit[0];
  assign byp1_data = byp_data[0];
  assign byp2_hit  = byp_hit[1];
  assign byp2_data = byp_data[1];
endmodule

// File: tb/tb_wb_queue.sv
// Randomized bench for wb_queue against a queue-based reference model and an external register file.

module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [4:0]    in_addr;
  logic [31:0]   in_data;
  logic          wb_hold;
  logic          regW;
  logic [4:0]    wrA;
  logic [31:0]   wrD;
  logic [4:0]    r1A, r2A;
  logic          byp1_hit, byp2_hit;
  logic [31:0]   byp1_data, byp2_data;
  logic [31:0]   pending;
  logic [CW-1:0] count;

  wb_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wb_hold(wb_hold),
    .regW(regW), .wrA(wrA), .wrD(wrD),
    .r1A(r1A), .r2A(r2A),
    .byp1_hit(byp1_hit), .byp1_data(byp1_data),
    .byp2_hit(byp2_hit), .byp2_data(byp2_data),
    .pending(pending), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External register file: captures on the negedge inside a regW cycle.
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(negedge clk) if (regW) rf[wrA] <= wrD;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_regW;
  logic [4:0]  m_wrA;
  logic [31:0] m_wrD;
  logic [31:0] exp_rf [32];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void mbyp(input logic [4:0] ra, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (ra == 5'd0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == ra) begin
        hit = 1'b1;
        d   = mq[i].d;
        return;
      end
    end
    if (m_regW && m_wrA == ra) begin
      hit = 1'b1;
      d   = m_wrD;
    end
  endfunction

  function automatic logic [31:0] mpend();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].a] = 1'b1;
    if (m_regW) p[m_wrA] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic void mreset();
    mq.delete();
    m_regW = 1'b0;
    m_wrA  = '0;
    m_wrD  = '0;
  endfunction

  // One clock: apply inputs, check at the negedge, advance the model at the posedge.
  task automatic cyc(input logic v, input logic [4:0] a, input logic [31:0] d,
                     input logic h, input logic [4:0] p1, input logic [4:0] p2);
    logic        ready, h1, h2;
    logic [31:0] d1, d2;
    in_valid = v; in_addr = a; in_data = d; wb_hold = h; r1A = p1; r2A = p2;
    @(negedge clk);
    ready = mq.size() < DEPTH;
    mbyp(p1, h1, d1);
    mbyp(p2, h2, d2);
    chk("in_ready", in_ready, ready);
    chk("count", count, mq.size());
    chk("regW", regW, m_regW);
    chk("wrA", wrA, m_wrA);
    chk("wrD", wrD, m_wrD);
    chk("pending", pending, mpend());
    chk("byp1_hit", byp1_hit, h1);
    chk("byp1_data", byp1_data, d1);
    chk("byp2_hit", byp2_hit, h2);
    chk("byp2_data", byp2_data, d2);
    if (m_regW) exp_rf[m_wrA] = m_wrD;
    @(posedge clk);
    if (!h && mq.size() > 0) begin
      m_regW = 1'b1;
      m_wrA  = mq[0].a;
      m_wrD  = mq[0].d;
      void'(mq.pop_front());
    end else begin
      m_regW = 1'b0;
    end
    if (v && ready && a != 5'd0) mq.push_back('{a: a, d: d});
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    mreset();
    rst = 1'b1; in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h1234; wb_hold = 1'b0;
    r1A = 5'd7; r2A = 5'd0;
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_regW", regW, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_pending", pending, 32'h0);
    chk("rst_byp1_hit", byp1_hit, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Quiet cycles after release: no pulse expected.
    repeat (2) cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);

    // Single write to r5.
    cyc(1'b1, 5'd5, 32'd100, 1'b0, 5'd5, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    chk("single_regW", regW, 1'b1);
    chk("single_wrA", wrA, 5'd5);
    chk("single_wrD", wrD, 32'd100);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    chk("single_rf5", rf[5], 32'd100);

    // Fill under hold, refuse the fifth, then drain.
    cyc(1'b1, 5'd1, 32'd10, 1'b1, 5'd1, 5'd4);
    cyc(1'b1, 5'd2, 32'd20, 1'b1, 5'd1, 5'd4);
    cyc(1'b1, 5'd3, 32'd30, 1'b1, 5'd1, 5'd4);
    cyc(1'b1, 5'd4, 32'd40, 1'b1, 5'd1, 5'd4);
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 1'b0);
    cyc(1'b1, 5'd6, 32'd60, 1'b1, 5'd6, 5'd4);
    chk("fill_refused_pend6", pending[6], 1'b0);
    repeat (6) cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 5'd3);
    chk("drain_count", count, 0);
    chk("drain_rf4", rf[4], 32'd40);

    // Zero register writes are swallowed.
    cyc(1'b1, 5'd0, 32'd77, 1'b0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    chk("zero_count", count, 0);
    chk("zero_pend0", pending[0], 1'b0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

    // Duplicate destination: youngest wins, then output stage.
    cyc(1'b1, 5'd3, 32'd11, 1'b1, 5'd3, 5'd4);
    cyc(1'b1, 5'd3, 32'd22, 1'b1, 5'd3, 5'd4);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd4);
    chk("dup_byp1_data", byp1_data, 32'd22);
    chk("dup_byp2_hit", byp2_hit, 1'b0);
    repeat (4) cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd4);
    chk("dup_rf3", rf[3], 32'd22);

    // Reset mid-drain: 4 queued, pop one, then async reset between edges.
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'(8 + i), 32'(1000 + i), 1'b1, 5'd8, 5'd11);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd8, 5'd11);
    #2 rst = 1'b1;
    #1;
    mreset();
    chk("mid_rst_regW", regW, 1'b0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_pending", pending, 32'h0);
    chk("mid_rst_byp1", byp1_hit, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd8, 5'd9);
    chk("mid_rst_rf8", rf[8], 32'd0);

    // Randomized traffic with a small address pool to force duplicates.
    for (int n = 0; n < 500; n++) begin
      cyc($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (DEPTH + 3) cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
    for (int i = 0; i < 32; i++) chk($sformatf("final_rf%0d", i), rf[i], exp_rf[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
